sweep_ctrl: RTL and testbench
=============================

Name: sweep_ctrl

Overview:
- Sequencer that drives the `counter` phase-accumulator control inputs (preload, pl_data, enable, updn, incr) to run automatic frequency sweeps.
- Sweep: preload a start phase, then step the increment from a start to a stop value, holding each value for a programmable dwell.
- Single-shot or continuous triangle (up/down) sweeps.
- Sits directly between the register/config interface and `counter`, replacing manual bench-style sequencing.

Parameters:
- INCR_W, 4, width of increment and config increment fields.
- PL_W, 4, width of preload data.
- DWELL_W, 16, width of dwell counter (cycles per increment value).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin sweep; sampled only in IDLE.
- abort  input  1  terminate sweep; highest priority after reset.
- cfg_start_incr  input  INCR_W  first increment value.
- cfg_stop_incr  input  INCR_W  final increment value.
- cfg_step  input  INCR_W  increment delta per dwell; 0 treated as 1.
- cfg_dwell  input  DWELL_W  enabled cycles per increment value; 0 treated as 1.
- cfg_preload  input  PL_W  phase preload value.
- cfg_updn  input  1  counter direction passed to counter.
- cfg_tri  input  1  1 = continuous triangle sweep, 0 = single shot.
- cnt_preload  output  1  to counter.preload.
- cnt_pl_data  output  PL_W  to counter.pl_data.
- cnt_enable  output  1  to counter.enable.
- cnt_updn  output  1  to counter.updn.
- cnt_incr  output  INCR_W  to counter.incr.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at single-shot completion.
- step_strobe  output  1  one-cycle pulse when cnt_incr changes.

Behaviour:
- All outputs registered.
- Reset values: cnt_preload=0, cnt_pl_data=0, cnt_enable=0, cnt_updn=1, cnt_incr=0, busy=0, done=0, step_strobe=0, state=IDLE.
- Reset assertion mid-sweep forces these values immediately, independent of clk.
- All cfg_* inputs are latched on the start edge. Later changes have no effect until the next start.
- FSM states: IDLE, LOAD, DWELL, DONE.
- IDLE:
  - start=1 at edge N → LOAD.
  - Cycle N+1: cnt_preload=1, cnt_pl_data=cfg_preload, cnt_incr=cfg_start_incr, cnt_updn=cfg_updn, busy=1, cnt_enable=0.
- LOAD: exactly one cycle → DWELL. In DWELL, cnt_preload=0 and cnt_enable=1.
- Direction and target:
  - dir = up if start_incr <= stop_incr, else down.
  - target = stop_incr.
- DWELL:
  - Dwell counter loads D-1, where D = max(cfg_dwell, 1), and decrements every cycle.
  - Each increment value is held for exactly D cycles with cnt_enable=1.
- Dwell expiry, cnt_incr != target:
  - On the same edge, cnt_incr moves one step toward target, saturating exactly at target (no overshoot, no wrap).
  - Dwell counter reloads; step_strobe=1 for one cycle.
  - No enable gap between values.
- Dwell expiry, cnt_incr == target, cfg_tri=0: → DONE.
- Dwell expiry, cnt_incr == target, cfg_tri=1:
  - Swap target between start_incr and stop_incr, invert dir, step immediately.
  - Continues until abort. done never pulses.
- start_incr == stop_incr: one dwell of D cycles, then DONE (single) or repeated dwell (tri) with no step_strobe.
- DONE: one cycle with done=1, busy=0, cnt_enable=0 → IDLE. cnt_incr keeps its last value.
- abort=1 in any non-IDLE state → IDLE on the next edge; cnt_enable=0, cnt_preload=0, busy=0, no done pulse.
- abort in IDLE is ignored. If start and abort are both high in IDLE, abort wins and the FSM stays IDLE.
- start while busy is ignored.

Optional Feature:
- Macro SWEEP_HOLD_EN.
- When defined: adds input `hold` (1 bit). While hold=1 in DWELL, the dwell counter freezes, cnt_enable=0, and no step occurs. Release resumes with the remaining dwell count. hold in LOAD/DONE/IDLE has no effect. abort overrides hold.
- When undefined: the port is absent and behaviour matches hold=0.

Test Plan:
- Reset with reset=0 for 3 cycles, release, no start → all outputs at reset values, busy=0 indefinitely.
- start with start=1, stop=4, step=1, dwell=3, preload=5, tri=0:
  - cnt_preload=1 with pl_data=5 for one cycle.
  - incr sequence 1,2,3,4, each held 3 enabled cycles; step_strobe ×3.
  - done pulse 13 cycles after LOAD.
- Saturation: start=2, stop=7, step=3, dwell=1 → incr 2,5,7, then done.
- Downward/degenerate:
  - start=6, stop=2, step=2, dwell=2 → 6,4,2, then done.
  - start=stop=3, dwell=0 → one 1-cycle dwell, then done, no strobe.
- Triangle: start=1, stop=3, step=1, dwell=2, tri=1 → 1,2,3,2,1,2,…; abort mid-dwell → next cycle IDLE, enable=0, no done.
- Reset mid-DWELL → outputs return to reset values asynchronously; a start after release restarts from LOAD. With SWEEP_HOLD_EN: hold for 10 cycles mid-dwell → enable low for 10 cycles, dwell length preserved.

Source files
------------

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: sequences counter preload/enable/updn/incr to run increment sweeps.
// Ports:
//   clk, reset (async, active low)
//   start, abort: sweep control; abort dominates once running
//   cfg_start_incr/cfg_stop_incr/cfg_step/cfg_dwell/cfg_preload/cfg_updn/cfg_tri: latched at start
//   cnt_preload/cnt_pl_data/cnt_enable/cnt_updn/cnt_incr: drive the counter
//   busy, done (single-shot completion pulse), step_strobe (cnt_incr changed)
//   hold: only present when SWEEP_HOLD_EN is defined; pauses the dwell
module sweep_ctrl #(
  parameter int INCR_W  = 4,
  parameter int PL_W    = 4,
  parameter int DWELL_W = 16
) (
`ifdef SWEEP_HOLD_EN
  input  logic               hold,
`endif
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [INCR_W-1:0]  cfg_start_incr,
  input  logic [INCR_W-1:0]  cfg_stop_incr,
  input  logic [INCR_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [PL_W-1:0]    cfg_preload,
  input  logic               cfg_updn,
  input  logic               cfg_tri,
  output logic               cnt_preload,
  output logic [PL_W-1:0]    cnt_pl_data,
  output logic               cnt_enable,
  output logic               cnt_updn,
  output logic [INCR_W-1:0]  cnt_incr,
  output logic               busy,
  output logic               done,
  output logic               step_strobe
);
  typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;
  state_t             state;
  logic [INCR_W-1:0]  r_start, r_stop, r_step, tgt;
  logic [DWELL_W-1:0] r_dm1, dcnt;
  logic               r_tri, dir, hold_i;
  logic [INCR_W-1:0]  swap_tgt;
`ifdef SWEEP_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif
  assign swap_tgt = (tgt == r_stop) ? r_start : r_stop;
  // One step from c toward t, landing exactly on t when the remaining gap is within s.
  function automatic logic [INCR_W-1:0] nxt(input logic [INCR_W-1:0] c, t, s, input logic up);
    logic [INCR_W-1:0] gap;
    gap = up ? t - c : c - t;
    return (gap <= s) ? t : (up ? c + s : c - s);
  endfunction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt_preload <= 1'b0;
      cnt_pl_data <= '0;
      cnt_enable  <= 1'b0;
      cnt_updn    <= 1'b1;
      cnt_incr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_strobe <= 1'b0;
      r_start     <= '0;
      r_stop      <= '0;
      r_step      <= '0;
      tgt         <= '0;
      r_dm1       <= '0;
      dcnt        <= '0;
      r_tri       <= 1'b0;
      dir         <= 1'b1;
    end else if (abort && state != IDLE) begin
      state       <= IDLE;
      cnt_preload <= 1'b0;
      cnt_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_strobe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done        <= 1'b0;
          step_strobe <= 1'b0;
          if (start && !abort) begin
            state       <= LOAD;
            r_start     <= cfg_start_incr;
            r_stop      <= cfg_stop_incr;
            tgt         <= cfg_stop_incr;
            dir         <= cfg_start_incr <= cfg_stop_incr;
            r_step      <= (cfg_step == '0) ? INCR_W'(1) : cfg_step;
            r_dm1       <= (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
            r_tri       <= cfg_tri;
            cnt_preload <= 1'b1;
            cnt_pl_data <= cfg_preload;
            cnt_incr    <= cfg_start_incr;
            cnt_updn    <= cfg_updn;
            cnt_enable  <= 1'b0;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          state       <= DWELL;
          cnt_preload <= 1'b0;
          cnt_enable  <= 1'b1;
          dcnt        <= r_dm1;
        end
        DWELL: begin
          step_strobe <= 1'b0;
          if (hold_i) begin
            cnt_enable <= 1'b0;
          end else begin
            cnt_enable <= 1'b1;
            if (dcnt != '0) begin
              dcnt <= dcnt - DWELL_W'(1);
            end else if (cnt_incr != tgt) begin
              cnt_incr    <= nxt(cnt_incr, tgt, r_step, dir);
              dcnt        <= r_dm1;
              step_strobe <= 1'b1;
            end else if (!r_tri) begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              cnt_enable <= 1'b0;
            end else begin
              // Triangle turnaround: retarget the other end and step right away.
              dcnt <= r_dm1;
              if (r_start != r_stop) begin
                tgt         <= swap_tgt;
                dir         <= ~dir;
                cnt_incr    <= nxt(cnt_incr, swap_tgt, r_step, ~dir);
                step_strobe <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed self-checking bench for sweep_ctrl.
module tb_sweep_ctrl;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0]  cfg_start_incr = '0, cfg_stop_incr = '0, cfg_step = '0, cfg_preload = '0;
  logic [15:0] cfg_dwell = '0;
  logic        cfg_updn = 1'b0, cfg_tri = 1'b0;
`ifdef SWEEP_HOLD_EN
  logic        hold = 1'b0;
`endif
  logic        cnt_preload, cnt_enable, cnt_updn, busy, done, step_strobe;
  logic [3:0]  cnt_pl_data, cnt_incr;
  int          checks = 0, failures = 0;
  logic [3:0]  ev [0:7];

  sweep_ctrl dut (
`ifdef SWEEP_HOLD_EN
    .hold(hold),
`endif
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_start_incr(cfg_start_incr), .cfg_stop_incr(cfg_stop_incr), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_preload(cfg_preload), .cfg_updn(cfg_updn), .cfg_tri(cfg_tri),
    .cnt_preload(cnt_preload), .cnt_pl_data(cnt_pl_data), .cnt_enable(cnt_enable),
    .cnt_updn(cnt_updn), .cnt_incr(cnt_incr), .busy(busy), .done(done), .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_pre"}, cnt_preload, 0);
    chk({tag, "_pld"}, cnt_pl_data, 0);
    chk({tag, "_en"}, cnt_enable, 0);
    chk({tag, "_updn"}, cnt_updn, 1);
    chk({tag, "_incr"}, cnt_incr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_stb"}, step_strobe, 0);
  endtask

  task automatic launch(input [3:0] si, so, st, input [15:0] dw, input [3:0] pl, input ud, tr);
    cfg_start_incr = si; cfg_stop_incr = so; cfg_step = st; cfg_dwell = dw;
    cfg_preload = pl; cfg_updn = ud; cfg_tri = tr;
    start = 1'b1;
    tick();
    start = 1'b0;
    // scramble config to prove it was latched at start
    cfg_start_incr = ~si; cfg_stop_incr = ~so; cfg_step = 4'd9; cfg_dwell = 16'd7;
    cfg_preload = ~pl; cfg_updn = ~ud; cfg_tri = ~tr;
    chk("load_pre", cnt_preload, 1);
    chk("load_pld", cnt_pl_data, pl);
    chk("load_incr", cnt_incr, si);
    chk("load_updn", cnt_updn, ud);
    chk("load_busy", busy, 1);
    chk("load_en", cnt_enable, 0);
  endtask

  task automatic run_single(input [3:0] si, so, st, input [15:0] dw, input [3:0] pl, input ud, input int n);
    int d;
    d = (dw == 0) ? 1 : int'(dw);
    launch(si, so, st, dw, pl, ud, 1'b0);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < d; j++) begin
        tick();
        chk("dw_en", cnt_enable, 1);
        chk("dw_pre", cnt_preload, 0);
        chk("dw_incr", cnt_incr, ev[i]);
        chk("dw_stb", step_strobe, (j == 0 && i > 0) ? 1 : 0);
        chk("dw_busy", busy, 1);
        chk("dw_done", done, 0);
      end
    tick();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_en", cnt_enable, 0);
    chk("done_incr", cnt_incr, ev[n-1]);
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk_rst("rst");
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_busy_hold", busy, 0);
      chk("idle_en_hold", cnt_enable, 0);
    end
    chk_rst("post_rst");

    ev[0] = 1; ev[1] = 2; ev[2] = 3; ev[3] = 4;
    run_single(4'd1, 4'd4, 4'd1, 16'd3, 4'd5, 1'b1, 4);

    ev[0] = 2; ev[1] = 5; ev[2] = 7;
    run_single(4'd2, 4'd7, 4'd3, 16'd1, 4'd9, 1'b0, 3);

    ev[0] = 6; ev[1] = 4; ev[2] = 2;
    run_single(4'd6, 4'd2, 4'd2, 16'd2, 4'd3, 1'b1, 3);

    ev[0] = 3;
    run_single(4'd3, 4'd3, 4'd1, 16'd0, 4'd0, 1'b0, 1);

    ev[0] = 4; ev[1] = 5;
    run_single(4'd4, 4'd5, 4'd0, 16'd2, 4'd1, 1'b1, 2);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_pre", cnt_preload, 0);

    ev[0] = 1; ev[1] = 2; ev[2] = 3; ev[3] = 2; ev[4] = 1; ev[5] = 2; ev[6] = 3;
    launch(4'd1, 4'd3, 4'd1, 16'd2, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 2; j++) begin
        tick();
        chk("tri_en", cnt_enable, 1);
        chk("tri_incr", cnt_incr, ev[i]);
        chk("tri_stb", step_strobe, (j == 0 && i > 0) ? 1 : 0);
        chk("tri_done", done, 0);
      end
    tick();
    chk("tri_turn_incr", cnt_incr, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_en", cnt_enable, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_nodone", done, 0);
      chk("abort_idle", busy, 0);
    end

    launch(4'd2, 4'd9, 4'd1, 16'd4, 4'd6, 1'b0, 1'b0);
    repeat (6) tick();
    chk("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1 chk_rst("async_rst");
    tick();
    reset = 1'b1;
    tick();
    chk("rel_busy", busy, 0);
    ev[0] = 7; ev[1] = 8;
    run_single(4'd7, 4'd8, 4'd1, 16'd1, 4'd4, 1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
